// File: rtl/pipe_pkg.sv
// Shared pipeline constants, EX-stage field bundle and ID/EX sequencer state encoding.
package pipe_pkg;

    localparam logic [3:0] REG_NONE  = 4'b1111;
    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        BUBBLE = 2'b01,
        HOLD   = 2'b10
    } idex_state_e;

    typedef struct packed {
        logic [3:0]  r1;
        logic [3:0]  r2;
        logic [3:0]  wreg;
        logic [15:0] rdata1;
        logic [15:0] rdata2;
        logic [15:0] imm;
        logic [1:0]  mem_control;
        logic [3:0]  alu_op;
    } ex_fields_t;

    // A bubble names no registers and touches no memory, so it can never cause a hazard.
    localparam ex_fields_t EX_BUBBLE = '{
        r1:          REG_NONE,
        r2:          REG_NONE,
        wreg:        REG_NONE,
        rdata1:      16'h0000,
        rdata2:      16'h0000,
        imm:         16'h0000,
        mem_control: MEM_NONE,
        alu_op:      4'h0
    };

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline boundary: decoded ID fields, kill/busy controls, EX fields and stall back to IF/ID.
interface id_ex_stage_if;

    logic [3:0]  id_R1;
    logic [3:0]  id_R2;
    logic [15:0] id_RData1;
    logic [15:0] id_RData2;
    logic [3:0]  id_WReg;
    logic [1:0]  id_MemControl;
    logic [3:0]  id_ALUOp;
    logic [15:0] id_Imm;
    logic        flush;
    logic        mem_busy;

    logic [3:0]  ex_R1;
    logic [3:0]  ex_R2;
    logic [3:0]  ex_WReg;
    logic [15:0] ex_RData1;
    logic [15:0] ex_RData2;
    logic [15:0] ex_Imm;
    logic [1:0]  ex_MemControl;
    logic [3:0]  ex_ALUOp;
    logic        stall_id;

    modport master (
        output id_R1, id_R2, id_RData1, id_RData2, id_WReg, id_MemControl, id_ALUOp, id_Imm,
               flush, mem_busy,
        input  ex_R1, ex_R2, ex_WReg, ex_RData1, ex_RData2, ex_Imm, ex_MemControl, ex_ALUOp,
               stall_id
    );

    modport slave (
        input  id_R1, id_R2, id_RData1, id_RData2, id_WReg, id_MemControl, id_ALUOp, id_Imm,
               flush, mem_busy,
        output ex_R1, ex_R2, ex_WReg, ex_RData1, ex_RData2, ex_Imm, ex_MemControl, ex_ALUOp,
               stall_id
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use compare: EX holds a load whose destination is a source of the ID instruction.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [1:0] ex_mem_control,
    input  logic [3:0] ex_wreg,
    input  logic [3:0] id_r1,
    input  logic [3:0] id_r2,
    output logic       load_use
);

    logic r1_hit;
    logic r2_hit;

    assign r1_hit   = (id_r1 != REG_NONE) && (id_r1 == ex_wreg);
    assign r2_hit   = (id_r2 != REG_NONE) && (id_r2 == ex_wreg);
    assign load_use = (ex_mem_control == MEM_READ) && (ex_wreg != REG_NONE) && (r1_hit || r2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble, MEM-busy hold and flush sequencing.
// Optional stall-cycle counter output enabled by defining IDEX_STALL_CNT_EN.
module id_ex_stage
    import pipe_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    id_ex_stage_if.slave    bus
`ifdef IDEX_STALL_CNT_EN
    ,
    output logic [15:0]     stall_cnt
`endif
);

    // state  | meaning
    // RUN    | normal flow, load-use checked each cycle
    // BUBBLE | bubble sits in EX; stalled ID instruction loads this cycle
    // HOLD   | MEM busy; EX frozen, ID stalled

    idex_state_e state_q, state_d;
    ex_fields_t  ex_q, ex_d, id_fields;
    logic        load_use;
    logic        stall_raw;

    assign id_fields = '{
        r1:          bus.id_R1,
        r2:          bus.id_R2,
        wreg:        bus.id_WReg,
        rdata1:      bus.id_RData1,
        rdata2:      bus.id_RData2,
        imm:         bus.id_Imm,
        mem_control: bus.id_MemControl,
        alu_op:      bus.id_ALUOp
    };

    hazard_detect u_hazard_detect (
        .ex_mem_control (ex_q.mem_control),
        .ex_wreg        (ex_q.wreg),
        .id_r1          (bus.id_R1),
        .id_r2          (bus.id_R2),
        .load_use       (load_use)
    );

    always_comb begin
        state_d   = state_q;
        ex_d      = ex_q;
        stall_raw = 1'b0;
        if (bus.flush) begin
            ex_d    = EX_BUBBLE;
            state_d = RUN;
        end else if (bus.mem_busy) begin
            stall_raw = 1'b1;
            state_d   = HOLD;
        end else begin
            unique case (state_q)
                // Leaving HOLD re-checks the hazard so a load frozen in EX still protects its consumer.
                RUN, HOLD: begin
                    if (load_use) begin
                        stall_raw = 1'b1;
                        ex_d      = EX_BUBBLE;
                        state_d   = BUBBLE;
                    end else begin
                        ex_d    = id_fields;
                        state_d = RUN;
                    end
                end
                BUBBLE: begin
                    ex_d    = id_fields;
                    state_d = RUN;
                end
                default: begin
                    ex_d    = EX_BUBBLE;
                    state_d = RUN;
                end
            endcase
        end
    end

    assign bus.stall_id = stall_raw & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            ex_q    <= EX_BUBBLE;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
        end
    end

`ifdef IDEX_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'h0000;
        end else if (bus.stall_id && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'h0001;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign bus.ex_R1         = ex_q.r1;
    assign bus.ex_R2         = ex_q.r2;
    assign bus.ex_WReg       = ex_q.wreg;
    assign bus.ex_RData1     = ex_q.rdata1;
    assign bus.ex_RData2     = ex_q.rdata2;
    assign bus.ex_Imm        = ex_q.imm;
    assign bus.ex_MemControl = ex_q.mem_control;
    assign bus.ex_ALUOp      = ex_q.alu_op;

endmodule
